// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI flash byte master and its sequencer.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWait,
    StHold,
    StGap
  } spi_state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDSR  = 8'h05;

endpackage

// File: rtl/spi_byte_master_if.sv
// Byte handshake between the flash command sequencer (master) and the SPI byte engine (slave).
interface spi_byte_master_if;
  import spi_pkg::*;

  logic                  tx_valid;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_last;
  logic                  tx_ready;
  logic                  rx_valid;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  busy;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data, busy
  );

endinterface

// File: rtl/spi_half_tick.sv
// Loadable down-counter: one-cycle tick every (load value + 1) enabled cycles.
module spi_half_tick (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [7:0] i_load_val,
  output logic       o_tick
);

  logic [7:0] r_cnt;

  assign o_tick = i_en && (r_cnt == 8'd0);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_load || o_tick) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: shifts one byte per handshake, holds CS across a multi-byte transaction.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  spi_byte_master_if.slave   bus,
  output logic               spi_cs,
  output logic               spi_clk,
  output logic               MOSI,
  input  logic               MISO
);

  localparam logic [7:0] DivLoad = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLoad = 8'(CS_GAP - 1);

  spi_state_e r_state, w_state_d;

  logic       r_tx_ready, r_rx_valid, r_busy, r_cs, r_sclk, r_mosi, r_last;
  logic [7:0] r_rx_data, r_tx_shift, r_rx_shift;
  logic [2:0] r_bit_cnt;

  logic       w_tx_ready_d, w_rx_valid_d, w_busy_d, w_cs_d, w_sclk_d, w_mosi_d, w_last_d;
  logic [7:0] w_rx_data_d, w_tx_shift_d, w_rx_shift_d;
  logic [2:0] w_bit_cnt_d;

  logic       w_accept, w_tick, w_load, w_en, w_rise, w_fall, w_byte_end;
  logic [7:0] w_load_val;

  assign w_accept   = bus.tx_valid && r_tx_ready;
  assign w_en       = (r_state == StShift) || (r_state == StHold) || (r_state == StGap);
  assign w_rise     = (r_state == StShift) && w_tick && !r_sclk;
  assign w_fall     = (r_state == StShift) && w_tick && r_sclk;
  assign w_byte_end = w_fall && (r_bit_cnt == 3'd7);
  assign w_load     = w_accept || w_byte_end || ((r_state == StHold) && w_tick);
  // HOLD expiry reloads the counter with the CS gap; everything else times half-periods.
  assign w_load_val = (r_state == StHold) ? GapLoad : DivLoad;

  spi_half_tick u_half_tick (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (w_load_val),
    .o_tick     (w_tick)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StWait: if (w_accept) w_state_d = StShift;
      StShift:        if (w_byte_end) w_state_d = r_last ? StHold : StWait;
      StHold:         if (w_tick) w_state_d = StGap;
      StGap:          if (w_tick) w_state_d = StIdle;
      default:        w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_tx_ready_d = (w_state_d == StIdle) || (w_state_d == StWait);
    w_busy_d     = (w_state_d != StIdle);
    w_cs_d       = !((w_state_d == StShift) || (w_state_d == StWait) || (w_state_d == StHold));
    w_sclk_d     = r_sclk;
    if (w_rise) w_sclk_d = 1'b1;
    if (w_fall) w_sclk_d = 1'b0;
    w_mosi_d     = r_mosi;
    w_tx_shift_d = r_tx_shift;
    if (w_accept) begin
      w_mosi_d     = bus.tx_data[SPI_BYTE_W-1];
      w_tx_shift_d = bus.tx_data;
    end else if (w_fall && !w_byte_end) begin
      w_mosi_d     = r_tx_shift[6];
      w_tx_shift_d = {r_tx_shift[6:0], 1'b0};
    end else if ((r_state == StHold) && w_tick) begin
      w_mosi_d = 1'b0;
    end
    w_rx_shift_d = w_rise ? {r_rx_shift[6:0], MISO} : r_rx_shift;
    w_bit_cnt_d  = w_fall ? r_bit_cnt + 3'd1 : r_bit_cnt;
    w_rx_valid_d = w_byte_end;
    w_rx_data_d  = w_byte_end ? r_rx_shift : r_rx_data;
    w_last_d     = w_accept ? bus.tx_last : r_last;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_last     <= 1'b0;
      r_rx_data  <= 8'd0;
      r_tx_shift <= 8'd0;
      r_rx_shift <= 8'd0;
      r_bit_cnt  <= 3'd0;
    end else begin
      r_tx_ready <= w_tx_ready_d;
      r_rx_valid <= w_rx_valid_d;
      r_busy     <= w_busy_d;
      r_cs       <= w_cs_d;
      r_sclk     <= w_sclk_d;
      r_mosi     <= w_mosi_d;
      r_last     <= w_last_d;
      r_rx_data  <= w_rx_data_d;
      r_tx_shift <= w_tx_shift_d;
      r_rx_shift <= w_rx_shift_d;
      r_bit_cnt  <= w_bit_cnt_d;
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;
  assign bus.busy     = r_busy;
  assign spi_cs       = r_cs;
  assign spi_clk      = r_sclk;
  assign MOSI         = r_mosi;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: flash-like MISO bit-stream model plus transaction-level expectations.
module tb_spi_byte_master;
  import spi_pkg::*;

  localparam int D = 4;
  localparam int G = 4;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic spi_cs, spi_clk, MOSI;
  logic MISO    = 1'b1;

  spi_byte_master_if bus ();

  spi_byte_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .spi_cs  (spi_cs),
    .spi_clk (spi_clk),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  logic       mosi_bits[$];
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  int         cs_rise_q[$];
  int         rises = 0;
  logic [7:0] miso_bytes[$];
  int         miso_idx = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;

  function automatic logic miso_bit(input int idx);
    logic [7:0] b;
    if (idx / 8 >= miso_bytes.size()) return 1'b1;
    b = miso_bytes[idx / 8];
    return b[7 - (idx % 8)];
  endfunction

  // Flash model shifts out a continuous bit stream from CS fall, advancing on each SCK fall.
  always @(negedge sys_clk) begin
    if (!spi_cs && prev_cs) miso_idx = 0;
    else if (!spi_clk && prev_sclk && !spi_cs) miso_idx = miso_idx + 1;
    MISO = miso_bit(miso_idx);
    if (spi_clk && !prev_sclk) begin
      rises = rises + 1;
      mosi_bits.push_back(MOSI);
    end
    if (spi_cs && !prev_cs) cs_rise_q.push_back(cyc);
    if (bus.rx_valid === 1'b1) begin
      rx_q.push_back(bus.rx_data);
      rx_cyc_q.push_back(cyc);
    end
    prev_cs   = spi_cs;
    prev_sclk = spi_clk;
  end

  task automatic clear_obs();
    mosi_bits.delete();
    rx_q.delete();
    rx_cyc_q.delete();
    cs_rise_q.delete();
    rises = 0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge, tx_valid still high.
  task automatic send(input logic [7:0] d, input bit last, output int acc, output bit ok);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = last;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 4000; i++) begin
      if (bus.tx_ready === 1'b1) begin
        @(posedge sys_clk);
        @(negedge sys_clk);
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge sys_clk);
      if (bus.tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_txn(input string name, input logic [7:0] tx[$], input logic [7:0] resp[$],
                        input int stall);
    int         n, acc_c, bad, ready_cyc, last_rx;
    int         acc[$];
    bit         ok;
    logic [7:0] t, e;
    n = tx.size();
    clear_obs();
    miso_bytes = resp;
    for (int i = 0; i < n; i++) begin
      send(tx[i], (i == n - 1), acc_c, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s accept byte %0d: got no tx_ready, required within 4000 cycles", name, i);
        bus.tx_valid = 1'b0;
        return;
      end
      acc.push_back(acc_c);
      if (i == n - 1) begin
        bus.tx_valid = 1'b0;
      end else if (stall > 0) begin
        bus.tx_valid = 1'b0;
        wait_ready(ok);
        bad = ok ? 0 : 1;
        repeat (stall) begin
          @(negedge sys_clk);
          if (spi_cs !== 1'b0 || spi_clk !== 1'b0 || bus.tx_ready !== 1'b1 || bus.busy !== 1'b1)
            bad++;
        end
        n_tests++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL %s wait_hold: %0d bad cycles, required 0", name, bad);
        end
      end
    end
    wait_ready(ok);
    ready_cyc = cyc;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s final_ready: tx_ready never returned", name);
      return;
    end
    n_tests++;
    if (rx_q.size() != n) begin
      n_fail++;
      $display("FAIL %s rx_count: got %0d, required %0d", name, rx_q.size(), n);
      return;
    end
    bad = 0;
    for (int i = 0; i < n; i++) begin
      e = (i < resp.size()) ? resp[i] : 8'hFF;
      if (rx_q[i] !== e) begin
        bad++;
        $display("FAIL %s rx_data[%0d]: got %h, required %h", name, i, rx_q[i], e);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    n_tests++;
    if (rises != 8 * n) begin
      n_fail++;
      $display("FAIL %s sck_rises: got %0d, required %0d", name, rises, 8 * n);
    end
    bad = 0;
    if (mosi_bits.size() != 8 * n) bad = 1;
    else
      for (int i = 0; i < 8 * n; i++) begin
        t = tx[i / 8];
        if (mosi_bits[i] !== t[7 - (i % 8)]) bad++;
      end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s mosi_bits: %0d wrong bits, required 0", name, bad);
    end
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (rx_cyc_q[i] - acc[i] != 16 * D) bad++;
      if (stall == 0 && i > 0 && acc[i] - rx_cyc_q[i - 1] != 1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s byte_timing: %0d latency/back-to-back errors, required 0 (first lat %0d, need %0d)",
               name, bad, rx_cyc_q[0] - acc[0], 16 * D);
    end
    last_rx = rx_cyc_q[n - 1];
    n_tests++;
    if (cs_rise_q.size() != 1 || cs_rise_q[0] != last_rx + D) begin
      n_fail++;
      $display("FAIL %s cs_release: got %0d rises (first at +%0d), required 1 at +%0d", name,
               cs_rise_q.size(), (cs_rise_q.size() > 0) ? cs_rise_q[0] - last_rx : -1, D);
    end
    n_tests++;
    if (ready_cyc != last_rx + D + G || bus.busy !== 1'b0 || spi_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_return: got +%0d busy=%b cs=%b, required +%0d busy=0 cs=1", name,
               ready_cyc - last_rx, bus.busy, spi_cs, D + G);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (spi_cs !== 1'b1 || spi_clk !== 1'b0 || MOSI !== 1'b0 || bus.tx_ready !== 1'b0 ||
          bus.rx_valid !== 1'b0 || bus.busy !== 1'b0)
        bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_values: %0d bad cycles, required 0", bad);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b, required 0", bus.tx_ready);
    end
    @(negedge sys_clk);
    n_tests++;
    if (bus.tx_ready !== 1'b1 || spi_cs !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_release: got ready=%b cs=%b busy=%b, required 1 1 0",
               bus.tx_ready, spi_cs, bus.busy);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] tq[$], rq[$];
    tq = '{8'hA5};
    rq.delete();
    do_txn("single_a5", tq, rq, 0);
  endtask

  task automatic test_jedec();
    logic [7:0] tq[$], rq[$];
    tq = '{CMD_JEDEC, 8'h00, 8'h00, 8'h00};
    rq = '{8'hFF, 8'hEF, 8'h40, 8'h18};
    do_txn("jedec", tq, rq, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] tq[$], rq[$];
    tq = '{CMD_READ, 8'h00, 8'h10, 8'h00, 8'($urandom)};
    rq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    do_txn("back_to_back", tq, rq, 0);
  endtask

  task automatic test_stalled_wait();
    logic [7:0] tq[$], rq[$];
    tq = '{8'h3C, 8'hC3, 8'h5A};
    rq = '{8'h81, 8'h7E, 8'h00};
    do_txn("stalled_wait", tq, rq, 100);
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] tq[$], rq[$];
    int acc_c;
    bit ok;
    clear_obs();
    miso_bytes.delete();
    send(8'($urandom), 1'b1, acc_c, ok);
    bus.tx_valid = 1'b0;
    for (int k = 0; k < 2000 && rises < 3; k++) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || rises < 3 || spi_cs !== 1'b1 || spi_clk !== 1'b0 || bus.tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got ok=%b rises=%0d cs=%b sck=%b ready=%b, required 1 3 1 0 0",
               ok, rises, spi_cs, spi_clk, bus.tx_ready);
    end
    repeat (5) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (80) @(negedge sys_clk);
    n_tests++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_rx: got %0d rx_valid pulses, required 0", rx_q.size());
    end
    tq = '{8'($urandom), 8'($urandom)};
    rq = '{8'($urandom), 8'($urandom)};
    do_txn("after_mid_reset", tq, rq, 0);
  endtask

  task automatic test_random();
    logic [7:0] tq[$], rq[$];
    int n, stall;
    for (int t = 0; t < 6; t++) begin
      tq.delete();
      rq.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        tq.push_back(8'($urandom));
        rq.push_back(8'($urandom));
      end
      stall = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      do_txn($sformatf("random%0d", t), tq, rq, stall);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    test_reset();
    test_single_byte();
    test_jedec();
    test_back_to_back();
    test_stalled_wait();
    test_reset_mid_byte();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
- Byte-level SPI mode-0 master that drives the flash pins (spi_cs, spi_clk, MOSI, MISO).
- Sits directly below the spi_flash command sequencer. The sequencer pushes command, address and dummy bytes through a valid/ready handshake and receives each returned byte as a one-cycle rx_valid pulse.
- Chip select is held low across a multi-byte transaction and released after the byte flagged tx_last.

Parameters:
- CLK_DIV, 4: spi_clk half-period in sys_clk cycles. Legal range is 2 to 255. SCK frequency = f_sys / (2*CLK_DIV).
- CS_GAP, 4: minimum spi_cs high time between transactions, in sys_clk cycles. Must be at least 1.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_valid  in  1  tx_data/tx_last are presented.
- tx_data  in  8  byte to shift out, MSB first.
- tx_last  in  1  release spi_cs after this byte.
- tx_ready  out  1  block can accept a byte.
- rx_valid  out  1  one-cycle pulse; rx_data is valid.
- rx_data  out  8  byte captured from MISO, MSB first.
- busy  out  1  high while spi_cs is low or the CS_GAP timer is running.
- spi_cs  out  1  flash chip select, active low.
- spi_clk  out  1  serial clock; idles low (CPOL=0).
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

Behaviour:
- Reset values (rst_n low, asynchronous): spi_cs=1, spi_clk=0, MOSI=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, state=IDLE.
  - tx_ready rises on the first sys_clk edge after rst_n is released.
  - Reset asserted mid-byte aborts immediately: outputs go to reset values and no rx_valid is produced.
- All outputs are registered.
- States: IDLE, SHIFT, WAIT, HOLD, GAP.
- Handshake: a byte is accepted on any edge where tx_valid && tx_ready. tx_ready=1 only in IDLE and WAIT. tx_valid while tx_ready=0 is ignored, and the upstream holds it.
- IDLE, on accept -> SHIFT:
  - spi_cs=0 and MOSI=tx_data[7] on the accept edge.
  - tx_last is latched.
- SHIFT, mode 0:
  - spi_clk toggles every CLK_DIV cycles, giving 8 rising edges.
  - MISO is sampled on the sys_clk edge that drives spi_clk high.
  - MOSI advances to the next bit on the edge that drives spi_clk low.
  - After the 8th high half, spi_clk returns low and rx_valid=1 for exactly one cycle with rx_data = the captured byte.
  - The rx_valid edge is 16*CLK_DIV cycles after the accept edge.
- After the byte:
  - latched tx_last=0 -> WAIT. spi_cs stays 0, spi_clk stays 0, tx_ready=1.
  - latched tx_last=1 -> HOLD.
- WAIT:
  - On accept -> SHIFT with no spi_cs deassertion. MOSI=tx_data[7] on the accept edge; the next byte begins with its first low half.
  - Back-to-back: if tx_valid is held high, accept occurs on the edge after rx_valid.
  - WAIT may last indefinitely.
- HOLD: CLK_DIV cycles with spi_cs=0, then spi_cs=1 and MOSI=0 -> GAP.
- GAP: CS_GAP cycles with tx_ready=0, then -> IDLE.
- Bit counter: 3 bits, wraps 7->0 only at byte end. Half-period counter: 8 bits, reloads to CLK_DIV-1.
- busy=1 in SHIFT, WAIT, HOLD and GAP.

Decomposition:
- Package spi_pkg holds:
  - the state enumeration (IDLE, SHIFT, WAIT, HOLD, GAP);
  - constant SPI_BYTE_W = 8;
  - flash opcode constants used by the sequencer: CMD_READ=8'h03, CMD_JEDEC=8'h9F, CMD_WREN=8'h06, CMD_RDSR=8'h05.
- One sub-module, spi_half_tick: a loadable down-counter that emits a one-cycle tick every CLK_DIV cycles while enabled. It is reused for the HOLD and GAP timing.

Test Plan:
- Reset check: hold rst_n low for 20 cycles, release -> spi_cs=1, spi_clk=0, MOSI=0 throughout reset; tx_ready=1 one cycle after release.
- Single byte, CLK_DIV=4: tx_data=8'hA5, tx_last=1, MISO tied 1 -> MOSI bits 1,0,1,0,0,1,0,1 stable at each spi_clk rise; exactly 8 rising edges; rx_valid at accept+64 cycles with rx_data=8'hFF; spi_cs high 4 cycles later; tx_ready returns after a further 4 cycles.
- JEDEC read: bytes 9F,00,00,00, last flagged on the 4th; bench MISO model returns EF,40,18 after the opcode -> rx_data sequence FF(or don't-care),EF,40,18; spi_cs never rises between bytes.
- Back-to-back: tx_valid held high with 03,00,10,00,xx -> next byte accepted on the edge after each rx_valid; no extra spi_clk pulse or glitch between bytes.
- Stalled WAIT: leave tx_valid low for 100 cycles between bytes -> spi_cs stays 0, spi_clk stays 0, tx_ready stays 1; transfer resumes correctly.
- Reset mid-byte: drop rst_n after the 3rd spi_clk rise -> spi_cs=1 and spi_clk=0 asynchronously, no rx_valid; the next transaction after release completes correctly.
